// File: rtl/siu_pkg.sv
// Shared types and constants for the sigmoid input unit (accumulate -> LUT address).
package siu_pkg;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned LUT_AW = 9;
  localparam logic [LUT_AW-1:0] ADDR_MAX = 9'h1FF;

endpackage

// File: rtl/sigmoid_addr_gen_sat_add.sv
// Combinational saturating signed add of a narrow product into the wide accumulator.
module sat_add #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned IN_W  = 16
) (
  input  logic signed [ACC_W-1:0] a_i,
  input  logic signed [IN_W-1:0]  b_i,
  output logic signed [ACC_W-1:0] sum_o,
  output logic                    clamp_o
);

  localparam int unsigned SW = ACC_W + 1;

  logic signed [SW-1:0] wide;

  // One guard bit: the top two bits disagree exactly when the true sum leaves the ACC_W range.
  always_comb begin
    wide    = SW'(a_i) + SW'(b_i);
    clamp_o = wide[SW-1] ^ wide[SW-2];
    if (clamp_o) begin
      sum_o = wide[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sum_o = wide[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/sigmoid_addr_gen.sv
// Accumulates a neuron's product stream and emits the sigmoid LUT address, sign and overflow flag.
module sigmoid_addr_gen
  import siu_pkg::*;
#(
  parameter int unsigned IN_W       = 16,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned ADDR_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [LUT_AW-1:0] addr,
  output logic              sign,
  output logic              ovf,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     sat_q, sat_d;
  logic [LUT_AW-1:0]        addr_q, addr_d;
  logic                     sign_q, sign_d;
  logic                     ovf_q, ovf_d;
  logic                     s_ready_q, s_ready_d;
  logic                     m_valid_q, m_valid_d;

  logic                     beat_c;
  logic signed [ACC_W-1:0]  sum_c;
  logic                     clamp_c;
  logic [ACC_W-1:0]         mag_c;
  logic [ACC_W-1:0]         mag_hi_c;
  logic                     mag_clamp_c;
  logic                     slice_ovf_c;

  assign beat_c = s_valid & s_ready_q;

  sat_add #(
    .ACC_W (ACC_W),
    .IN_W  (IN_W)
  ) u_sat_add (
    .a_i     (acc_q),
    .b_i     (s_data),
    .sum_o   (sum_c),
    .clamp_o (clamp_c)
  );

  // Magnitude of the sum; the most-negative value has no positive twin and is pinned to max.
  always_comb begin
    mag_clamp_c = (acc_q == ACC_MIN);
    if (mag_clamp_c) begin
      mag_c = ACC_MAX;
    end else if (acc_q[ACC_W-1]) begin
      mag_c = -acc_q;
    end else begin
      mag_c = acc_q;
    end
    mag_hi_c    = mag_c >> ADDR_SHIFT;
    slice_ovf_c = |mag_hi_c[ACC_W-1:LUT_AW];
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    addr_d    = addr_q;
    sign_d    = sign_q;
    ovf_d     = ovf_q;
    m_valid_d = 1'b0;

    unique case (state_q)
      ACC: begin
        if (beat_c) begin
          acc_d = sum_c;
          sat_d = sat_q | clamp_c;
          if (s_last) begin
            state_d = CONV;
          end
        end
      end
      CONV: begin
        sign_d  = acc_q[ACC_W-1];
        sat_d   = sat_q | mag_clamp_c;
        ovf_d   = sat_q | mag_clamp_c | slice_ovf_c;
        addr_d  = (sat_q | mag_clamp_c | slice_ovf_c) ? ADDR_MAX : mag_hi_c[LUT_AW-1:0];
        state_d = HOLD;
      end
      HOLD: begin
        // m_valid lags entry into HOLD by one cycle, so m_ready only counts once it is visible.
        if (m_valid_q && m_ready) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = ACC;
        end else begin
          m_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase

    s_ready_d = (state_d == ACC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      addr_q    <= '0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      addr_q    <= addr_d;
      sign_q    <= sign_d;
      ovf_q     <= ovf_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign s_ready = s_ready_q;
  assign addr    = addr_q;
  assign sign    = sign_q;
  assign ovf     = ovf_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_sigmoid_addr_gen.sv
// Self-checking bench for sigmoid_addr_gen: directed corner neurons plus random neurons vs. an integer model.
module tb_sigmoid_addr_gen;

  localparam int unsigned IN_W       = 16;
  localparam int unsigned ACC_W      = 24;
  localparam int unsigned ADDR_SHIFT = 4;
  localparam longint      AMAX       = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint      AMIN       = -(longint'(1) <<< (ACC_W - 1));

  logic            clk = 1'b0;
  logic            rst_n;
  logic [IN_W-1:0] s_data;
  logic            s_valid;
  logic            s_last;
  logic            s_ready;
  logic [8:0]      addr;
  logic            sign;
  logic            ovf;
  logic            m_valid;
  logic            m_ready;

  int n_vec = 0;
  int n_err = 0;
  int beats[$];

  sigmoid_addr_gen #(
    .IN_W       (IN_W),
    .ACC_W      (ACC_W),
    .ADDR_SHIFT (ADDR_SHIFT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .addr    (addr),
    .sign    (sign),
    .ovf     (ovf),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: integer sum with per-beat clamping, then sign/magnitude and address slicing.
  task automatic model(output int e_addr, output int e_sign, output int e_ovf);
    longint acc = 0;
    longint mag;
    bit     sat = 0;
    foreach (beats[i]) begin
      acc = acc + beats[i];
      if (acc > AMAX) begin acc = AMAX; sat = 1; end
      if (acc < AMIN) begin acc = AMIN; sat = 1; end
    end
    e_sign = (acc < 0) ? 1 : 0;
    mag    = (acc < 0) ? -acc : acc;
    if (mag > AMAX) begin mag = AMAX; sat = 1; end
    e_ovf  = (sat || (mag / (longint'(1) <<< ADDR_SHIFT)) > 511) ? 1 : 0;
    e_addr = e_ovf ? 511 : int'((mag / (longint'(1) <<< ADDR_SHIFT)) % 512);
  endtask

  task automatic send_beat(input string tag, input int d, input bit last);
    int t = 0;
    s_data  = IN_W'(d);
    s_valid = 1'b1;
    s_last  = last;
    while (!s_ready && t < 50) begin
      tick();
      t++;
    end
    if (!s_ready) chk({tag, "_sready_timeout"}, 0, 1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_neuron(input string tag, input int bp, input bit chk_lat);
    int e_addr, e_sign, e_ovf;
    int t;
    model(e_addr, e_sign, e_ovf);
    foreach (beats[i]) send_beat(tag, beats[i], (i == beats.size() - 1));
    tick();
    if (chk_lat) chk({tag, "_mvalid_t1"}, m_valid, 0);
    tick();
    t = 2;
    while (!m_valid && t < 20) begin
      tick();
      t++;
    end
    if (chk_lat) chk({tag, "_latency"}, t, 2);
    chk({tag, "_mvalid"}, m_valid, 1);
    chk({tag, "_addr"}, addr, e_addr);
    chk({tag, "_sign"}, sign, e_sign);
    chk({tag, "_ovf"}, ovf, e_ovf);
    chk({tag, "_sready_busy"}, s_ready, 0);
    if (bp > 0) begin
      s_data  = 16'h1234;
      s_valid = 1'b1;
      s_last  = 1'b0;
      repeat (bp) begin
        tick();
        chk({tag, "_bp_mvalid"}, m_valid, 1);
        chk({tag, "_bp_sready"}, s_ready, 0);
        chk({tag, "_bp_addr"}, addr, e_addr);
        chk({tag, "_bp_sign"}, sign, e_sign);
        chk({tag, "_bp_ovf"}, ovf, e_ovf);
      end
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    s_valid = 1'b0;
    chk({tag, "_mvalid_drop"}, m_valid, 0);
    chk({tag, "_sready_back"}, s_ready, 1);
    chk({tag, "_addr_kept"}, addr, e_addr);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("rst_sready", s_ready, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_addr", addr, 0);
    chk("rst_sign", sign, 0);
    chk("rst_ovf", ovf, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rel_sready_low", s_ready, 0);
    tick();
    chk("rel_sready_high", s_ready, 1);

    beats = '{100, 200, -50};
    run_neuron("sum250", 0, 1'b1);
    beats = '{-1000};
    run_neuron("single_neg", 0, 1'b1);
    beats = '{30000, 30000};
    run_neuron("slice_ovf", 0, 1'b1);
    beats = '{};
    repeat (300) beats.push_back(32767);
    run_neuron("sat_pos", 0, 1'b0);
    beats = '{};
    repeat (256) beats.push_back(-32768);
    run_neuron("most_neg", 0, 1'b0);
    beats = '{5, -5};
    run_neuron("zero", 0, 1'b0);
    beats = '{1000};
    run_neuron("pre_bp", 5, 1'b0);
    beats = '{7};
    run_neuron("after_bp", 0, 1'b0);
    beats = '{2000};
    run_neuron("pre_rst", 0, 1'b0);

    // Partial neuron then asynchronous reset between clock edges.
    send_beat("mid", 100, 1'b0);
    send_beat("mid", 200, 1'b0);
    send_beat("mid", 300, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sready", s_ready, 0);
    chk("arst_mvalid", m_valid, 0);
    chk("arst_addr", addr, 0);
    chk("arst_sign", sign, 0);
    chk("arst_ovf", ovf, 0);
    tick();
    #2;
    rst_n = 1'b1;
    beats = '{48};
    run_neuron("post_rst", 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int len;
      len = int'($urandom_range(1, 8));
      beats = '{};
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) beats.push_back(int'($urandom_range(0, 65535)) - 32768);
        else beats.push_back(int'($urandom_range(0, 4000)) - 2000);
      end
      run_neuron($sformatf("rnd%0d", n), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sigmoid_addr_gen.md
Name: sigmoid_addr_gen

Overview:
- Front end of the sigmoid lookup path.
- Accepts a serial stream of signed neuron products over a valid/ready handshake and accumulates them into a saturating signed accumulator.
- At the last beat it converts the sum into the sign/magnitude form the sigmoid lookup consumes: 9-bit address, sign flag, overflow flag.
- Presents that result on a second valid/ready handshake and holds it until accepted.

Parameters:
- IN_W, 16, width of signed input product.
- ACC_W, 24, width of signed accumulator (must be >= IN_W+1 and >= ADDR_SHIFT+10).
- ADDR_SHIFT, 4, LSB position of magnitude slice driven onto addr.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_data  input  IN_W  signed product, two's complement.
- s_valid  input  1  s_data/s_last valid.
- s_last  input  1  final product of current neuron.
- s_ready  output  1  block accepts a beat this cycle.
- addr  output  9  magnitude slice for sigmoid LUT.
- sign  output  1  1 = accumulated sum negative.
- ovf  output  1  magnitude exceeds addr range or accumulator saturated.
- m_valid  output  1  addr/sign/ovf valid.
- m_ready  input  1  consumer accepts result.

Behaviour:
- Reset (async assert, sync release): state=ACC, acc=0, sat=0, addr=0, sign=0, ovf=0, m_valid=0. s_ready goes to 1 on the first cycle after release.
- FSM has three states.
- ACC state:
  - s_ready=1, m_valid=0.
  - A beat transfers when s_valid&s_ready.
  - acc_next = acc + sign-extended s_data, clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets sticky sat.
  - A beat with s_last=1 moves to CONV. Otherwise stay in ACC.
- CONV state (one cycle):
  - s_ready=0.
  - sign_r = acc[ACC_W-1].
  - mag = |acc|, with most-negative clamped to 2^(ACC_W-1)-1 (also sets sat).
  - ovf_r = sat OR (mag >> ADDR_SHIFT) > 511.
  - addr_r = ovf_r ? 9'h1FF : mag[ADDR_SHIFT+8:ADDR_SHIFT].
  - Move to HOLD.
- HOLD state:
  - m_valid=1, s_ready=0.
  - addr/sign/ovf are stable while m_valid&!m_ready.
  - On m_ready: acc=0, sat=0, go to ACC. m_valid drops the next cycle; addr/sign/ovf keep last values.
- Latency: last beat accepted at edge T; m_valid=1 after edge T+2. Minimum neuron period is N beats + 2 cycles + handshake.
- Single-beat neuron (first beat has s_last) is legal.
- Throughput: no new beat is accepted until the result is taken. There is no overlap between neurons.
- s_valid asserted while s_ready=0: beat not taken, no state change. The producer must hold it.
- Zero sum: sign=0, addr=0, ovf=0.
- Reset mid-operation: partial accumulation and pending result are discarded; outputs return to reset values immediately.
- m_ready while m_valid=0: ignored.
- Registered outputs only; no combinational path from s_* to m_* or from m_ready to s_ready.

Decomposition:
- Shared package siu_pkg holds:
  - state enum (ACC, CONV, HOLD);
  - LUT address width constant 9;
  - max-address constant 9'h1FF.
- One sub-module, sat_add: combinational saturating signed adder, ACC_W plus extended IN_W, producing a sum and a clamp flag.
- Abs/slice logic stays inline.

Test Plan:
- Beats 100, 200, -50(last), m_ready=1 -> sign=0, addr=15, ovf=0; m_valid exactly 2 cycles after last beat.
- Single beat -1000(last) -> sign=1, addr=62, ovf=0.
- Beats 30000, 30000(last) -> sum 60000 ≥ 8192 -> ovf=1, addr=0x1FF, sign=0.
- 300 beats of 32767 -> accumulator clamps at 8388607, sat sticky -> ovf=1, addr=0x1FF; 256 beats of -32768 -> acc=-8388608 -> sign=1, ovf=1.
- Backpressure:
  - hold m_ready=0 for 5 cycles after m_valid -> addr/sign/ovf constant, s_ready=0, s_valid beats not consumed;
  - release -> next neuron starts from acc=0 (beat 7(last) -> addr=0, sign=0).
- Assert rst_n low mid-neuron after 3 beats -> all outputs 0 asynchronously; after release, beat 48(last) -> addr=3, not contaminated by prior beats.
